data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 25 ++
 rtl/data_cache_single_port_bram.sv | 40 ++++
 rtl/data_cache.sv | 161 ++++++++++++++++
 tb/tb_data_cache.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: instruction opcodes, controller
// states and the bit positions inside the sticky error vector.
package data_cache_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_SMA    = 4'b0110,
    OP_LOADI  = 4'b0111,
    OP_SENDL  = 4'b1000,
    OP_LOADB  = 4'b1001,
    OP_WRITEB = 4'b1010
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUF  = 2'd1,
    READ_WAIT = 2'd2,
    OUT_HOLD  = 2'd3
  } state_e;

  localparam int ERR_OPCODE = 0;
  localparam int ERR_WORD   = 1;
  localparam int ERR_ADDR   = 2;

endpackage

// File: rtl/data_cache_single_port_bram.sv
// Single-port line storage, read-first.
// Ports: clk_in clock; en enables the port; we writes wdata at addr;
// rdata returns the pre-write contents of addr `latency` cycles after en.
// Contents have no reset, so they survive a controller reset.
module single_port_bram #(
  parameter int width   = 96,
  parameter int depth   = 384,
  parameter int latency = 2
) (
  input  logic                     clk_in,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];
  logic [width-1:0] rdata_p0;

  // Stage 0: array access (old data is read out before the write lands)
  always_ff @(posedge clk_in) begin
    if (en) begin
      rdata_p0 <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

  generate
    if (latency == 2) begin : g_lat2
      logic [width-1:0] rdata_p1;
      // Stage 1: optional output register
      always_ff @(posedge clk_in) rdata_p1 <= rdata_p0;
      assign rdata = rdata_p1;
    end else begin : g_lat1
      assign rdata = rdata_p0;
    end
  endgenerate

endmodule

// File: rtl/data_cache.sv
// Line cache feeding FMA operand triples (a b c per FMA).
// Ports: clk_in/rst_in clock and async active-high reset; instr_in/valid/
// ready instruction handshake (op [0:3], reg [4:7], imm [8:23]);
// buffer_line_in/valid/ready line from the FMA write buffer; abc_out/valid/
// ready line read back to the FMAs; error_out sticky error flags.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int FMA_COUNT    = 2,
  parameter int WORD_WIDTH   = 16,
  parameter int DEPTH        = 384,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [0:31]                            instr_in,
  input  logic                                   instr_valid_in,
  output logic                                   instr_ready_out,
  input  logic [3*FMA_COUNT*WORD_WIDTH-1:0]      buffer_line_in,
  input  logic                                   buffer_valid_in,
  output logic                                   buffer_ready_out,
  output logic [3*FMA_COUNT*WORD_WIDTH-1:0]      abc_out,
  output logic                                   abc_valid_out,
  input  logic                                   abc_ready_in,
  output logic [2:0]                             error_out
);

  localparam int WORDS      = 3 * FMA_COUNT;
  localparam int LINE_WIDTH = WORDS * WORD_WIDTH;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  opcode_e               opc;
  logic [3:0]            rsel;
  logic [15:0]           imm;
  logic                  imm_ok;
  logic                  unused_bits;

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LINE_WIDTH-1:0] staging;
  logic [1:0]            wait_cnt;

  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata, mem_rdata;

  assign opc         = opcode_e'(instr_in[0:3]);
  assign rsel        = instr_in[4:7];
  assign imm         = instr_in[8:23];
  assign unused_bits = ^instr_in[24:31];
  assign imm_ok      = (32'(imm) < DEPTH);

  assign instr_ready_out = (state == IDLE);

  always_comb begin
    state_nxt        = state;
    mem_en           = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = addr;
    mem_wdata        = staging;
    buffer_ready_out = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid_in) begin
          case (opc)
            OP_SENDL: begin
              mem_en = 1'b1;
              mem_we = 1'b1;
            end
            OP_LOADB:  if (imm_ok) state_nxt = WAIT_BUF;
            OP_WRITEB: begin
              // Read is launched in the accepting cycle so the result is
              // back BRAM_LATENCY cycles later.
              if (imm_ok) begin
                mem_en    = 1'b1;
                mem_addr  = imm[ADDR_WIDTH-1:0];
                state_nxt = READ_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_BUF: begin
        if (buffer_valid_in) begin
          buffer_ready_out = 1'b1;
          mem_en           = 1'b1;
          mem_we           = 1'b1;
          mem_wdata        = buffer_line_in;
          state_nxt        = IDLE;
        end
      end
      READ_WAIT: if (wait_cnt == 2'(BRAM_LATENCY - 1)) state_nxt = OUT_HOLD;
      OUT_HOLD:  if (abc_ready_in) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // Storage must never be touched while reset is asserted.
    if (rst_in) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      addr          <= '0;
      staging       <= '0;
      wait_cnt      <= '0;
      abc_out       <= '0;
      abc_valid_out <= 1'b0;
      error_out     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid_in) begin
        case (opc)
          OP_NOP: ;
          OP_SMA, OP_LOADB, OP_WRITEB: begin
            if (imm_ok) addr <= imm[ADDR_WIDTH-1:0];
            else        error_out[ERR_ADDR] <= 1'b1;
          end
          OP_LOADI: begin
            if (32'(rsel) < WORDS) begin
              for (int w = 0; w < WORDS; w++)
                if (32'(rsel) == w)
                  staging[LINE_WIDTH-(w+1)*WORD_WIDTH +: WORD_WIDTH] <= WORD_WIDTH'(imm);
            end else begin
              error_out[ERR_WORD] <= 1'b1;
            end
          end
          OP_SENDL: staging <= '0;
          default:  error_out[ERR_OPCODE] <= 1'b1;
        endcase
      end
      if (state == READ_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
        if (state_nxt == OUT_HOLD) begin
          abc_out       <= mem_rdata;
          abc_valid_out <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      if (state == OUT_HOLD && abc_ready_in) abc_valid_out <= 1'b0;
    end
  end

  single_port_bram #(
    .width   (LINE_WIDTH),
    .depth   (DEPTH),
    .latency (BRAM_LATENCY)
  ) u_bram (
    .clk_in (clk_in),
    .en     (mem_en),
    .we     (mem_we),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: default configuration (dut_a) and a
// 4-FMA / single-cycle-latency configuration (dut_b).
module tb_data_cache;
  import data_cache_pkg::*;

  localparam int LW_A  = 96;
  localparam int LW_B  = 192;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [0:31]     instr;
  logic            vld_a, vld_b;
  logic            rdy_a, rdy_b;
  logic [LW_A-1:0] bline_a;
  logic [LW_B-1:0] bline_b;
  logic            bvld_a, bvld_b;
  logic            brdy_a, brdy_b;
  logic [LW_A-1:0] abc_a;
  logic [LW_B-1:0] abc_b;
  logic            abcv_a, abcv_b;
  logic            abc_ready;
  logic [2:0]      err_a, err_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  always #5 clk_in = ~clk_in;

  data_cache dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr), .instr_valid_in(vld_a),
    .instr_ready_out(rdy_a), .buffer_line_in(bline_a), .buffer_valid_in(bvld_a),
    .buffer_ready_out(brdy_a), .abc_out(abc_a), .abc_valid_out(abcv_a),
    .abc_ready_in(abc_ready), .error_out(err_a));

  data_cache #(.FMA_COUNT(4), .BRAM_LATENCY(1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr), .instr_valid_in(vld_b),
    .instr_ready_out(rdy_b), .buffer_line_in(bline_b), .buffer_valid_in(bvld_b),
    .buffer_ready_out(brdy_b), .abc_out(abc_b), .abc_valid_out(abcv_b),
    .abc_ready_in(abc_ready), .error_out(err_b));

  always @(posedge clk_in) if (brdy_a) pulses++;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one instruction for one cycle; returns on the negedge after
  // the accepting posedge.
  task automatic issue(input bit b, input logic [3:0] op, input logic [3:0] rg, input logic [15:0] im);
    instr = {op, rg, im, 8'h00};
    if (b) vld_b = 1'b1; else vld_a = 1'b1;
    @(negedge clk_in);
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask

  // WRITEB with abc_ready high: checks latency, data, and the one-cycle
  // handshake returning to IDLE.
  task automatic read_line(input bit b, input logic [15:0] im, input int lat,
                           input logic [191:0] exp, input string name);
    int cnt;
    issue(b, OP_WRITEB, 4'd0, im);
    cnt = 1;
    while (!(b ? abcv_b : abcv_a) && cnt < 30) begin
      @(negedge clk_in);
      cnt++;
    end
    check({name, "_latency"}, 192'(cnt), 192'(lat + 1));
    check({name, "_data"}, b ? abc_b : 192'(abc_a), exp);
    @(negedge clk_in);
    check({name, "_valid_drop"}, 192'(b ? abcv_b : abcv_a), 192'(0));
    check({name, "_ready_back"}, 192'(b ? rdy_b : rdy_a), 192'(1));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rg;
    logic [15:0] im;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [96:0]      dummy;
    logic [LW_A-1:0]  line_a;
    logic [LW_A-1:0]  a5_line;
    logic [LW_A-1:0]  held;
    logic [LW_B-1:0]  line_b;

    line_a  = 96'h111122223333444455556666;
    a5_line = {12{8'hA5}};
    dummy   = '0;

    for (int i = 0; i < 6; i++)
      tbl[i] = '{OP_LOADI, 4'(i), 16'(16'h1111 * (i + 1)), 3'b000};
    tbl[6]  = '{OP_SMA,    4'd0, 16'd5,    3'b000};
    tbl[7]  = '{OP_SENDL,  4'd0, 16'd0,    3'b000};
    tbl[8]  = '{OP_LOADI,  4'd6, 16'hDEAD, 3'b010};
    tbl[9]  = '{4'hF,      4'd0, 16'd0,    3'b011};
    tbl[10] = '{OP_WRITEB, 4'd0, 16'd600,  3'b111};
    tbl[11] = '{OP_SMA,    4'd0, 16'd500,  3'b111};
    tbl[12] = '{OP_LOADB,  4'd0, 16'd384,  3'b111};
    tbl[13] = '{OP_NOP,    4'd0, 16'd0,    3'b111};

    rst_in = 1'b1; instr = '0; vld_a = 0; vld_b = 0;
    bvld_a = 0; bvld_b = 0; bline_a = '0; bline_b = '0; abc_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_instr_ready", 192'(rdy_a), 192'(1));
    check("rst_abc_valid", 192'(abcv_a), 192'(0));
    check("rst_abc_out", 192'(abc_a), 192'(0));
    check("rst_error", 192'(err_a), 192'(0));
    check("rst_buffer_ready", 192'(brdy_a), 192'(0));

    for (int i = 0; i < 14; i++) begin
      issue(1'b0, tbl[i].op, tbl[i].rg, tbl[i].im);
      check($sformatf("vec%0d_ready", i), 192'(rdy_a), 192'(1));
      check($sformatf("vec%0d_error", i), 192'(err_a), 192'(tbl[i].exp_err));
    end

    read_line(1'b0, 16'd5, LAT_A, 192'(line_a), "writeb5");
    // Staging was cleared by SENDL and the bad LOADI must not have touched it.
    issue(1'b0, OP_SMA, 4'd0, 16'd9);
    issue(1'b0, OP_SENDL, 4'd0, 16'd0);
    read_line(1'b0, 16'd9, LAT_A, 192'(0), "writeb9_zero");

    // Downstream stall for 10 cycles.
    abc_ready = 1'b0;
    issue(1'b0, OP_WRITEB, 4'd0, 16'd5);
    for (int i = 0; i < 30 && !abcv_a; i++) @(negedge clk_in);
    held = abc_a;
    check("stall_first_data", 192'(held), 192'(line_a));
    for (int i = 0; i < 10; i++) begin
      check("stall_data", 192'(abc_a), 192'(line_a));
      check("stall_valid", 192'(abcv_a), 192'(1));
      check("stall_instr_ready", 192'(rdy_a), 192'(0));
      @(negedge clk_in);
    end
    abc_ready = 1'b1;
    @(negedge clk_in);
    check("stall_release_valid", 192'(abcv_a), 192'(0));
    check("stall_release_ready", 192'(rdy_a), 192'(1));

    // Buffer load with a delayed source.
    pulses = 0;
    issue(1'b0, OP_LOADB, 4'd0, 16'd7);
    for (int i = 0; i < 4; i++) begin
      check("loadb_wait_bready", 192'(brdy_a), 192'(0));
      check("loadb_wait_iready", 192'(rdy_a), 192'(0));
      @(negedge clk_in);
    end
    bline_a = a5_line;
    bvld_a  = 1'b1;
    #1;
    check("loadb_bready_pulse", 192'(brdy_a), 192'(1));
    @(negedge clk_in);
    check("loadb_bready_drop", 192'(brdy_a), 192'(0));
    check("loadb_iready_back", 192'(rdy_a), 192'(1));
    repeat (3) @(negedge clk_in);
    bvld_a = 1'b0;
    check("loadb_pulse_count", 192'(pulses), 192'(1));
    read_line(1'b0, 16'd7, LAT_A, 192'(a5_line), "writeb7");
    read_line(1'b0, 16'd5, LAT_A, 192'(line_a), "writeb5_again");

    // Reset while a read is in flight.
    issue(1'b0, OP_WRITEB, 4'd0, 16'd7);
    rst_in = 1'b1;
    #1;
    check("midrst_instr_ready", 192'(rdy_a), 192'(1));
    check("midrst_abc_valid", 192'(abcv_a), 192'(0));
    check("midrst_abc_out", 192'(abc_a), 192'(0));
    check("midrst_error", 192'(err_a), 192'(0));
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("postrst_abc_valid", 192'(abcv_a), 192'(0));
    read_line(1'b0, 16'd7, LAT_A, 192'(a5_line), "postrst_writeb7");
    read_line(1'b0, 16'd5, LAT_A, 192'(line_a), "postrst_writeb5");

    // Wide configuration, single-cycle storage latency.
    line_b = '0;
    for (int i = 0; i < 12; i++) begin
      issue(1'b1, OP_LOADI, 4'(i), 16'(16'h1111 * (i + 1)));
      line_b = {line_b[LW_B-17:0], 16'(16'h1111 * (i + 1))};
    end
    issue(1'b1, OP_SMA, 4'd0, 16'd5);
    issue(1'b1, OP_SENDL, 4'd0, 16'd0);
    check("b_error", 192'(err_b), 192'(0));
    read_line(1'b1, 16'd5, LAT_B, line_b, "b_writeb5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
